// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
//   Shared definitions for the TDM serial link (transmitter and receiver).
//   - state_e        : receiver framing states (PAR only reachable when
//                      TDM_RX_PARITY_EN is defined)
//   - NCH_DEFAULT    : default channels per frame
//   - SEL_W_DEFAULT  : default slot counter width (log2 of NCH_DEFAULT)
//   - tdm_parity()   : even parity over up to 16 data bits; callers
//                      zero-extend narrower frames
// ---------------------------------------------------------------------------
package tdm_pkg;

  localparam int NCH_DEFAULT   = 8;
  localparam int SEL_W_DEFAULT = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_e;

  // Zero-extension of a narrower frame does not change the XOR result.
  function automatic logic tdm_parity(input logic [15:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tdm_slot_decoder.sv
// ---------------------------------------------------------------------------
// tdm_slot_decoder
//   SEL_W-to-NCH one-hot decoder gated by an enable. Turns the receiver slot
//   counter into per-bit write enables for the shift buffer, mirroring the
//   select decode of the transmit multiplexer.
//   Ports:
//     sel_i    [SEL_W-1:0]  slot index
//     en_i                  gate; all outputs are 0 when low
//     onehot_o [NCH-1:0]    onehot_o[sel_i] = en_i
// ---------------------------------------------------------------------------
module tdm_slot_decoder
  import tdm_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [NCH-1:0]   onehot_o
);

  // NOTE: assigning a default before any conditional assignment keeps a
  // combinational block from inferring a latch.
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tdm_demux_rx
//   Receive end of the TDM serial link. Rebuilds an NCH-bit parallel frame
//   from a one-bit stream, one bit per enabled slot, aligned by a sync marker
//   that accompanies every slot-0 bit.
//   Optional feature macro: TDM_RX_PARITY_EN adds a trailing even-parity slot
//   per frame (state PAR); when undefined, par_err is tied to 0.
//   Ports:
//     clk          clock, all activity on the rising edge
//     rst          synchronous, active-high reset
//     sin          serial data bit for the current slot
//     en           bit strobe; sin/sync sampled only when high
//     sync         frame marker, high on the slot-0 bit of each frame
//     q            last complete frame, q[k] = bit from slot k
//     frame_valid  one-cycle pulse, q just updated
//     locked       receiver aligned to frames
//     slot         index of the next slot to be received
//     sync_err     one-cycle pulse on alignment fault
//     par_err      one-cycle pulse on parity failure
// ---------------------------------------------------------------------------
module tdm_demux_rx
  import tdm_pkg::*;
#(
  parameter int NCH   = NCH_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  input  logic             sync,
  output logic [NCH-1:0]   q,
  output logic             frame_valid,
  output logic             locked,
  output logic [SEL_W-1:0] slot,
  output logic             sync_err,
  output logic             par_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NCH - 1);
  localparam logic [SEL_W-1:0] ONE       = SEL_W'(1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] slot_q, slot_d;
  logic [NCH-1:0]   buf_q, buf_d;
  logic [NCH-1:0]   frame_q, frame_d;
  logic             fv_q, fv_d;
  logic             locked_q, locked_d;
  logic             serr_q, serr_d;
  logic             perr_q, perr_d;

  logic             buf_write;
  logic [NCH-1:0]   buf_we;

  // An in-order data bit: slot 0 must carry sync, every other slot must not.
  // Out-of-order bits (resync, lost lock) are handled by the FSM instead.
  assign buf_write = en && (state_q == RECV) && ((slot_q == '0) == sync);

  tdm_slot_decoder #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_slot_decoder (
    .sel_i    (slot_q),
    .en_i     (buf_write),
    .onehot_o (buf_we)
  );

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    buf_d    = buf_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    locked_d = locked_q;
    serr_d   = 1'b0;
    perr_d   = 1'b0;

    for (int k = 0; k < NCH; k++) begin
      if (buf_we[k]) buf_d[k] = sin;
    end

    if (en) begin
      unique case (state_q)
        HUNT: begin
          if (sync) begin
            buf_d    = {{(NCH-1){1'b0}}, sin};
            slot_d   = ONE;
            locked_d = 1'b1;
            state_d  = RECV;
          end
        end

        RECV: begin
          if (slot_q == '0) begin
            if (sync) begin
              slot_d = ONE;
            end else begin
              // Missing marker where a frame should start: drop the bit.
              serr_d   = 1'b1;
              locked_d = 1'b0;
              slot_d   = '0;
              state_d  = HUNT;
            end
          end else if (sync) begin
            // Marker arrived early: discard the partial frame, restart at 0.
            serr_d = 1'b1;
            buf_d  = {{(NCH-1){1'b0}}, sin};
            slot_d = ONE;
          end else if (slot_q == LAST_SLOT) begin
`ifdef TDM_RX_PARITY_EN
            // Slot stays at NCH-1 while the parity bit is awaited.
            state_d = PAR;
`else
            frame_d = {sin, buf_q[NCH-2:0]};
            fv_d    = 1'b1;
            slot_d  = '0;
`endif
          end else begin
            slot_d = slot_q + ONE;
          end
        end

`ifdef TDM_RX_PARITY_EN
        PAR: begin
          if (sync) begin
            serr_d  = 1'b1;
            buf_d   = {{(NCH-1){1'b0}}, sin};
            slot_d  = ONE;
            state_d = RECV;
          end else begin
            if (tdm_parity(16'(buf_q)) ^ sin) begin
              perr_d = 1'b1;
            end else begin
              frame_d = buf_q;
              fv_d    = 1'b1;
            end
            slot_d  = '0;
            state_d = RECV;
          end
        end
`endif

        default: begin
          state_d  = HUNT;
          slot_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is checked first so it wins over a
  // frame-completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      buf_q    <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      buf_q    <= buf_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
      perr_q   <= perr_d;
    end
  end

  assign q           = frame_q;
  assign frame_valid = fv_q;
  assign locked      = locked_q;
  assign slot        = slot_q;
  assign sync_err    = serr_q;
  assign par_err     = perr_q;

endmodule

// File: tb/tb_tdm_demux_rx.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_rx
//   Self-checking bench for tdm_demux_rx (NCH=8). Expected frames are queued
//   as the final bit of a good frame is driven and compared whenever the DUT
//   raises frame_valid. Builds with or without TDM_RX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_tdm_demux_rx;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sin = 1'b0;
  logic             en = 1'b0;
  logic             sync = 1'b0;
  logic [NCH-1:0]   q;
  logic             frame_valid;
  logic             locked;
  logic [SEL_W-1:0] slot;
  logic             sync_err;
  logic             par_err;

  int               n_vec = 0;
  int               n_bad = 0;
  logic [NCH-1:0]   sb_q[$];
  logic             fv_prev = 1'b0;

  tdm_demux_rx #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sin         (sin),
    .en          (en),
    .sync        (sync),
    .q           (q),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One enabled bit; returns #1 after the sampling edge with en low again.
  task automatic send_bit(input logic s, input logic y);
    @(negedge clk);
    sin  = s;
    sync = y;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    sin  = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends slots first..NCH-1 of frame d (plus the parity slot when enabled,
  // corrupted if bad=1) and checks the completion-edge pulses.
  task automatic send_slots(input logic [NCH-1:0] d, input int first, input logic bad);
    logic exp_fv;
    logic exp_perr;
    exp_fv   = 1'b1;
    exp_perr = 1'b0;
    for (int k = first; k < NCH; k++) begin
`ifndef TDM_RX_PARITY_EN
      if (k == NCH - 1) sb_q.push_back(d);
`endif
      send_bit(d[k], k == 0);
    end
`ifdef TDM_RX_PARITY_EN
    exp_fv   = !bad;
    exp_perr = bad;
    check("par_slot", 32'(slot), 32'(NCH - 1));
    check("par_fv_early", 32'(frame_valid), 32'd0);
    if (!bad) sb_q.push_back(d);
    send_bit((^d) ^ bad, 1'b0);
`endif
    check("fv_done", 32'(frame_valid), 32'(exp_fv));
    check("par_err", 32'(par_err), 32'(exp_perr));
  endtask

  // Scoreboard side: every frame_valid pulse must match a queued frame.
  always @(negedge clk) begin
    if (frame_valid) begin
      check("fv_width", 32'(fv_prev), 32'd0);
      if (sb_q.size() == 0) begin
        check("fv_unexpected", 32'(frame_valid), 32'd0);
      end else begin
        check("q_frame", 32'(q), 32'(sb_q.pop_front()));
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    logic [NCH-1:0] d;
    logic [NCH-1:0] last_d;

    // Reset state
    idle(3);
    check("rst_q", 32'(q), 32'd0);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_serr", 32'(sync_err), 32'd0);
    check("rst_perr", 32'(par_err), 32'd0);
    rst = 1'b0;
    idle(1);

    // Single frame, continuous strobe: slots 0..7 = 1,0,1,1,0,0,1,0
    send_slots(8'b0100_1101, 0, 1'b0);
    check("f1_q", 32'(q), 32'h4D);
    check("f1_locked", 32'(locked), 32'd1);
    check("f1_slot", 32'(slot), 32'd0);
    idle(1);
    check("f1_fv_drop", 32'(frame_valid), 32'd0);

    // Same frame with a 3-cycle strobe gap after slot 4
    d = 8'h4D;
    for (int k = 0; k < 5; k++) send_bit(d[k], k == 0);
    idle(3);
    check("gap_slot", 32'(slot), 32'd5);
    check("gap_fv", 32'(frame_valid), 32'd0);
    check("gap_locked", 32'(locked), 32'd1);
    send_slots(d, 5, 1'b0);
    check("gap_q", 32'(q), 32'h4D);

    // Early sync at slot 5: partial frame discarded, bit becomes slot 0
    d = 8'hFF;
    for (int k = 0; k < 5; k++) send_bit(d[k], k == 0);
    d = 8'h96;
    send_bit(d[0], 1'b1);
    check("mis_serr", 32'(sync_err), 32'd1);
    check("mis_locked", 32'(locked), 32'd1);
    check("mis_slot", 32'(slot), 32'd1);
    check("mis_q_hold", 32'(q), 32'h4D);
    check("mis_fv", 32'(frame_valid), 32'd0);
    send_slots(d, 1, 1'b0);
    check("mis_q_new", 32'(q), 32'h96);
    idle(1);
    check("mis_serr_drop", 32'(sync_err), 32'd0);

    // Missing sync at slot 0: lock lost, bits ignored until next sync
    send_bit(1'b1, 1'b0);
    check("lost_serr", 32'(sync_err), 32'd1);
    check("lost_locked", 32'(locked), 32'd0);
    check("lost_slot", 32'(slot), 32'd0);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    check("hunt_locked", 32'(locked), 32'd0);
    check("hunt_slot", 32'(slot), 32'd0);
    check("hunt_serr", 32'(sync_err), 32'd0);
    check("hunt_q", 32'(q), 32'h96);
    send_slots(8'h3C, 0, 1'b0);
    check("relock", 32'(locked), 32'd1);

    // Back-to-back frames
    last_d = 8'h3C;
    for (int f = 0; f < 4; f++) begin
      last_d = 8'($urandom);
      send_slots(last_d, 0, 1'b0);
    end

`ifdef TDM_RX_PARITY_EN
    // Parity: A5 has even weight, so parity bit 1 is a failure
    send_slots(8'hA5, 0, 1'b1);
    check("par_q_hold", 32'(q), 32'(last_d));
    idle(1);
    check("par_err_drop", 32'(par_err), 32'd0);
    send_slots(8'hA5, 0, 1'b0);
    check("par_q_new", 32'(q), 32'hA5);
`endif

    // Reset on the edge that samples slot 7
    d = 8'hE7;
    for (int k = 0; k < NCH - 1; k++) send_bit(d[k], k == 0);
    @(negedge clk);
    sin  = d[NCH-1];
    sync = 1'b0;
    en   = 1'b1;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    sin = 1'b0;
    rst = 1'b0;
    check("rst7_q", 32'(q), 32'd0);
    check("rst7_fv", 32'(frame_valid), 32'd0);
    check("rst7_locked", 32'(locked), 32'd0);
    check("rst7_slot", 32'(slot), 32'd0);

    send_slots(8'h5A, 0, 1'b0);
    check("post_rst_q", 32'(q), 32'h5A);

    idle(2);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
